// File: rtl/calc_pkg.sv
// Shared definitions for the MiniCalculator sequencer: key codes, the
// one-hot ALU operation encoding, sequencer states and result helpers.
package calc_pkg;

    // Keypad codes above the digit range
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_ADD       = 4'd10;
    localparam logic [3:0] KEY_SUB       = 4'd11;
    localparam logic [3:0] KEY_MUL       = 4'd12;
    localparam logic [3:0] KEY_DIV       = 4'd13;
    localparam logic [3:0] KEY_EQ        = 4'd14;
    localparam logic [3:0] KEY_CLR       = 4'd15;

    // One-hot operation codes understood by the ALU
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0001;
    localparam logic [3:0] OP_STOP = 4'b0000;

    // Largest operand the 4-bit signed Booth multiplier can take
    localparam logic [3:0] MUL_OPERAND_MAX = 4'd7;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        EXEC    = 3'd2,
        WAIT    = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= KEY_DIGIT_MAX);
    endfunction

    function automatic logic is_operator(input logic [3:0] code);
        return (code >= KEY_ADD) && (code <= KEY_DIV);
    endfunction

    // Translate an operator key into the one-hot ALU operation
    function automatic logic [3:0] key_to_op(input logic [3:0] code);
        logic [3:0] op;
        case (code)
            KEY_ADD: op = OP_ADD;
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_STOP;
        endcase
        return op;
    endfunction

    // The adder only produces a meaningful 5-bit field; sub is signed in
    // that field, add is unsigned, mul already fills all 8 bits.
    function automatic logic [7:0] normalise_result(input logic [3:0] op,
                                                    input logic [7:0] alu_o);
        logic [7:0] res;
        case (op)
            OP_ADD:  res = {3'b000, alu_o[4:0]};
            OP_SUB:  res = {{3{alu_o[4]}}, alu_o[4:0]};
            OP_MUL:  res = alu_o;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/calc_seq_if.sv
// Keypad handshake, ALU drive/return and display-side signals of calc_seq.
interface calc_seq_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] alu_op;
    logic [3:0] alu_data1;
    logic [3:0] alu_data2;
    logic [7:0] alu_o;
    logic       alu_busy;
    logic [7:0] result;
    logic       result_valid;
    logic       err;
    logic       ctrl_busy;

    // Environment side: keypad decoder, ALU and display
    modport master (
        output key_valid, key_code, alu_o, alu_busy,
        input  key_ready, alu_op, alu_data1, alu_data2,
        input  result, result_valid, err, ctrl_busy
    );

    // Sequencer side
    modport slave (
        input  key_valid, key_code, alu_o, alu_busy,
        output key_ready, alu_op, alu_data1, alu_data2,
        output result, result_valid, err, ctrl_busy
    );
endinterface

// File: rtl/calc_seq.sv
// Key-driven sequencer: gathers A, operator and B from the keypad, drives
// the ALU for the whole operation, waits out busy and captures the result.
module calc_seq
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 31
) (
    input logic      clk,
    input logic      rst,
    calc_seq_if.slave bus
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    state_t           state_r;
    state_t           state_next_s;
    logic [3:0]       a_r;
    logic [3:0]       a_next_s;
    logic [3:0]       b_r;
    logic [3:0]       b_next_s;
    logic [3:0]       op_r;
    logic [3:0]       op_next_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_next_s;
    logic             capture_s;
    logic             key_accept_s;
    logic             op_active_s;

    logic [3:0]       alu_op_r;
    logic [3:0]       alu_data1_r;
    logic [3:0]       alu_data2_r;
    logic [7:0]       result_r;
    logic             result_valid_r;
    logic             err_r;
    logic             ctrl_busy_r;
    logic             key_ready_r;

    assign key_accept_s = bus.key_valid & key_ready_r;
    assign op_active_s  = (state_next_s == EXEC) || (state_next_s == WAIT);

    // Next-state and operand/operator bookkeeping for every key and ALU event
    always_comb begin
        state_next_s    = state_r;
        a_next_s        = a_r;
        b_next_s        = b_r;
        op_next_s       = op_r;
        wait_cnt_next_s = wait_cnt_r;
        capture_s       = 1'b0;
        case (state_r)
            ENTER_A: begin
                if (!key_accept_s) begin
                    state_next_s = ENTER_A;
                end else if (is_digit(bus.key_code)) begin
                    a_next_s = bus.key_code;
                end else if (is_operator(bus.key_code)) begin
                    op_next_s    = key_to_op(bus.key_code);
                    state_next_s = ENTER_B;
                end else if (bus.key_code == KEY_CLR) begin
                    a_next_s  = 4'd0;
                    b_next_s  = 4'd0;
                    op_next_s = OP_STOP;
                end else begin
                    state_next_s = ENTER_A;
                end
            end
            ENTER_B: begin
                if (!key_accept_s) begin
                    state_next_s = ENTER_B;
                end else if (is_digit(bus.key_code)) begin
                    b_next_s = bus.key_code;
                end else if (is_operator(bus.key_code)) begin
                    op_next_s = key_to_op(bus.key_code);
                end else if (bus.key_code == KEY_EQ) begin
                    if (op_r == OP_DIV) begin
                        state_next_s = ERR;
                    end else if ((op_r == OP_MUL) &&
                                 ((a_r > MUL_OPERAND_MAX) || (b_r > MUL_OPERAND_MAX))) begin
                        state_next_s = ERR;
                    end else begin
                        state_next_s = EXEC;
                    end
                end else begin
                    a_next_s     = 4'd0;
                    b_next_s     = 4'd0;
                    op_next_s    = OP_STOP;
                    state_next_s = ENTER_A;
                end
            end
            EXEC: begin
                wait_cnt_next_s = '0;
                state_next_s    = WAIT;
            end
            WAIT: begin
                if (!bus.alu_busy) begin
                    capture_s    = 1'b1;
                    state_next_s = DONE;
                end else if (wait_cnt_r == CNT_LAST) begin
                    state_next_s = ERR;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (!key_accept_s) begin
                    state_next_s = DONE;
                end else if (is_digit(bus.key_code)) begin
                    a_next_s     = bus.key_code;
                    b_next_s     = 4'd0;
                    op_next_s    = OP_STOP;
                    state_next_s = ENTER_A;
                end else if (bus.key_code == KEY_CLR) begin
                    a_next_s     = 4'd0;
                    b_next_s     = 4'd0;
                    op_next_s    = OP_STOP;
                    state_next_s = ENTER_A;
                end else begin
                    state_next_s = DONE;
                end
            end
            ERR: begin
                if (key_accept_s && (bus.key_code == KEY_CLR)) begin
                    a_next_s     = 4'd0;
                    b_next_s     = 4'd0;
                    op_next_s    = OP_STOP;
                    state_next_s = ENTER_A;
                end else begin
                    state_next_s = ERR;
                end
            end
            default: begin
                a_next_s     = 4'd0;
                b_next_s     = 4'd0;
                op_next_s    = OP_STOP;
                state_next_s = ENTER_A;
            end
        endcase
    end

    // State, operand and WAIT-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ENTER_A;
            a_r        <= 4'd0;
            b_r        <= 4'd0;
            op_r       <= OP_STOP;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_next_s;
            a_r        <= a_next_s;
            b_r        <= b_next_s;
            op_r       <= op_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Registered outputs; the ALU sees an op only while EXEC/WAIT is next,
    // so op drops in the same cycle the result is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_r       <= OP_STOP;
            alu_data1_r    <= 4'd0;
            alu_data2_r    <= 4'd0;
            result_r       <= 8'h00;
            result_valid_r <= 1'b0;
            err_r          <= 1'b0;
            ctrl_busy_r    <= 1'b0;
            key_ready_r    <= 1'b0;
        end else begin
            alu_op_r       <= op_active_s ? op_next_s : OP_STOP;
            alu_data1_r    <= op_active_s ? a_next_s  : 4'd0;
            alu_data2_r    <= op_active_s ? b_next_s  : 4'd0;
            result_r       <= capture_s ? normalise_result(op_r, bus.alu_o) : result_r;
            result_valid_r <= capture_s;
            err_r          <= (state_next_s == ERR);
            ctrl_busy_r    <= op_active_s;
            key_ready_r    <= !op_active_s;
        end
    end

    assign bus.alu_op       = alu_op_r;
    assign bus.alu_data1    = alu_data1_r;
    assign bus.alu_data2    = alu_data2_r;
    assign bus.result       = result_r;
    assign bus.result_valid = result_valid_r;
    assign bus.err          = err_r;
    assign bus.ctrl_busy    = ctrl_busy_r;
    assign bus.key_ready    = key_ready_r;

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq: a tiny ALU stand-in, a key-level
// reference model with cycle arithmetic, directed cases and random keys.
module tb_calc_seq;
    import calc_pkg::*;

    localparam int TIMEOUT = 31;
    localparam int P_A = 0, P_B = 1, P_RUN = 2, P_DONE = 3, P_ERR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    calc_seq_if ifc();

    calc_seq #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mul_len  = 9;
    int step     = 0;

    // ---------------- ALU stand-in: upper bits of add/sub are junk ----------
    always @(posedge clk) begin
        if (rst) step <= 0;
        else if (ifc.alu_op == 4'b0010) begin
            if (step <= mul_len) step <= step + 1;
        end else step <= 0;
    end

    always_comb begin
        ifc.alu_busy = 1'b0;
        ifc.alu_o    = 8'h00;
        case (ifc.alu_op)
            4'b1000: ifc.alu_o = {3'b101, 5'({1'b0, ifc.alu_data1} + {1'b0, ifc.alu_data2})};
            4'b0100: ifc.alu_o = {3'b110, 5'({1'b0, ifc.alu_data1} - {1'b0, ifc.alu_data2})};
            4'b0010: begin
                ifc.alu_busy = (step >= 1) && (step <= mul_len);
                ifc.alu_o    = (step == mul_len + 1) ? 8'({4'b0, ifc.alu_data1} * {4'b0, ifc.alu_data2}) : 8'h5A;
            end
            default: ifc.alu_o = 8'h00;
        endcase
    end

    // ---------------- reference model --------------------------------------
    int         m_phase = P_A;
    int         m_a = 0, m_b = 0, m_op = 0, m_end = 0;
    bit         m_timeout = 0, m_rv = 0, m_kr = 0, m_seen = 0;
    logic [7:0] m_expres = 8'h00, m_result = 8'h00;

    function automatic logic [3:0] exp_onehot(input int k);
        case (k)
            10: return 4'b1000;
            11: return 4'b0100;
            12: return 4'b0010;
            13: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    always @(posedge clk) begin
        int k;
        int len;
        bit acc;
        cyc  = cyc + 1;
        m_rv = 1'b0;
        if (rst) begin
            m_phase = P_A; m_a = 0; m_b = 0; m_op = 0;
            m_result = 8'h00; m_kr = 1'b0; m_seen = 1'b1;
        end else begin
            acc = ifc.key_valid && m_kr;
            k   = int'(ifc.key_code);
            if (m_phase == P_RUN && cyc == m_end) begin
                if (m_timeout) m_phase = P_ERR;
                else begin m_phase = P_DONE; m_result = m_expres; m_rv = 1'b1; end
            end
            if (acc) begin
                if (k == 15 && m_phase != P_RUN) begin
                    m_phase = P_A; m_a = 0; m_b = 0; m_op = 0;
                end else if (m_phase == P_A) begin
                    if (k <= 9) m_a = k;
                    else if (k <= 13) begin m_op = k; m_phase = P_B; end
                end else if (m_phase == P_B) begin
                    if (k <= 9) m_b = k;
                    else if (k <= 13) m_op = k;
                    else if (m_op == 13 || (m_op == 12 && (m_a > 7 || m_b > 7))) m_phase = P_ERR;
                    else begin
                        len       = (m_op == 12) ? mul_len : 0;
                        m_timeout = (len > TIMEOUT);
                        m_end     = m_timeout ? cyc + 2 + TIMEOUT : cyc + 2 + len;
                        m_expres  = (m_op == 10) ? 8'(m_a + m_b) :
                                    (m_op == 11) ? 8'(m_a - m_b) : 8'(m_a * m_b);
                        m_phase   = P_RUN;
                    end
                end else if (m_phase == P_DONE && k <= 9) begin
                    m_a = k; m_b = 0; m_op = 0; m_phase = P_A;
                end
            end
            m_kr = (m_phase != P_RUN);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- per-cycle compare against the model ------------------
    always @(negedge clk) begin
        if (m_seen) begin
            chk("ctrl_busy", 32'(ifc.ctrl_busy), 32'(m_phase == P_RUN));
            chk("alu_op", 32'(ifc.alu_op), 32'((m_phase == P_RUN) ? exp_onehot(m_op) : 4'b0000));
            chk("key_ready", 32'(ifc.key_ready), 32'(m_kr));
            chk("err", 32'(ifc.err), 32'(m_phase == P_ERR));
            chk("result_valid", 32'(ifc.result_valid), 32'(m_rv));
            chk("result", 32'(ifc.result), 32'(m_result));
            chk("rv_err_excl", 32'(ifc.result_valid & ifc.err), 32'd0);
            if (m_phase == P_RUN) begin
                chk("alu_data1", 32'(ifc.alu_data1), 32'(m_a));
                chk("alu_data2", 32'(ifc.alu_data2), 32'(m_b));
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic press(input logic [3:0] k, output int acc_cyc);
        bit got;
        got = 1'b0;
        acc_cyc = -1;
        @(negedge clk);
        ifc.key_valid = 1'b1;
        ifc.key_code  = k;
        for (int i = 0; i < 200 && !got; i++) begin
            if (ifc.key_ready === 1'b1) begin
                @(posedge clk); #1;
                acc_cyc = cyc;
                got = 1'b1;
            end else @(negedge clk);
        end
        ifc.key_valid = 1'b0;
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL key_accept: key %0d not accepted within 200 cycles", k);
        end
    endtask

    task automatic expr(input logic [3:0] a, input logic [3:0] op, input logic [3:0] b, output int eq_cyc);
        int t;
        press(a, t); press(op, t); press(b, t); press(KEY_EQ, eq_cyc);
    endtask

    // Wait for result_valid (or err when want_err) and return its cycle
    task automatic wait_evt(input bit want_err, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            @(negedge clk);
            if ((want_err ? ifc.err : ifc.result_valid) === 1'b1) at = cyc;
        end
        if (at < 0) begin
            n_checks++; n_fail++;
            $display("FAIL wait_evt: no %s within %0d cycles", want_err ? "err" : "result_valid", limit);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int eq, at, t, busy_cnt, r;
        int lens[5];
        logic [3:0] k;
        lens = '{0, 3, 9, 31, 32};
        ifc.key_valid = 1'b0;
        ifc.key_code  = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_alu_op", 32'(ifc.alu_op), 32'd0);
        chk("reset_result", 32'(ifc.result), 32'd0);
        chk("reset_key_ready", 32'(ifc.key_ready), 32'd0);
        rst = 1'b0;

        // 3 + 4 = : op in EXEC and WAIT, result next cycle, op dropped
        expr(4'd3, KEY_ADD, 4'd4, eq);
        @(negedge clk); chk("add_op_exec", 32'(ifc.alu_op), 32'h8);
        @(negedge clk); chk("add_op_wait", 32'(ifc.alu_op), 32'h8);
        @(negedge clk);
        chk("add_rv", 32'(ifc.result_valid), 32'd1);
        chk("add_result", 32'(ifc.result), 32'h07);
        chk("add_op_done", 32'(ifc.alu_op), 32'h0);

        // 3 - 5 = -> -2
        expr(4'd3, KEY_SUB, 4'd5, eq);
        wait_evt(1'b0, 20, at);
        chk("sub_result", 32'(ifc.result), 32'hFE);
        chk("sub_latency", 32'(at - eq), 32'd2);

        // 7 * 6 = : op held 11 cycles, busy 9 cycles, then 42
        expr(4'd7, KEY_MUL, 4'd6, eq);
        busy_cnt = 0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            chk("mul_op_held", 32'(ifc.alu_op), 32'h2);
            if (ifc.alu_busy) busy_cnt++;
        end
        chk("mul_busy_cycles", 32'(busy_cnt), 32'd9);
        @(negedge clk);
        chk("mul_rv", 32'(ifc.result_valid), 32'd1);
        chk("mul_result", 32'(ifc.result), 32'h2A);
        chk("mul_op_drop", 32'(ifc.alu_op), 32'h0);
        expr(4'd2, KEY_MUL, 4'd3, eq);
        wait_evt(1'b0, 30, at);
        chk("mul2_result", 32'(ifc.result), 32'h06);

        // Rejected operations: 8 * 2 and 4 / 2
        expr(4'd8, KEY_MUL, 4'd2, eq);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mulbig_err", 32'(ifc.err), 32'd1);
            chk("mulbig_op", 32'(ifc.alu_op), 32'h0);
        end
        press(KEY_CLR, t);
        @(negedge clk); chk("clr_err", 32'(ifc.err), 32'd0);
        expr(4'd4, KEY_DIV, 4'd2, eq);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("div_err", 32'(ifc.err), 32'd1);
            chk("div_op", 32'(ifc.alu_op), 32'h0);
        end
        press(KEY_CLR, t);
        @(negedge clk); chk("clr_err2", 32'(ifc.err), 32'd0);

        // Digit 9 held through a multiply is taken in DONE and becomes A
        expr(4'd7, KEY_MUL, 4'd6, eq);
        press(4'd9, t);
        chk("stall_accept_cycle", 32'(t - eq), 32'd12);
        press(KEY_ADD, t); press(4'd1, t); press(KEY_EQ, eq);
        wait_evt(1'b0, 20, at);
        chk("stall_a_is_9", 32'(ifc.result), 32'h0A);

        // Reset in the 5th WAIT cycle of a multiply
        expr(4'd7, KEY_MUL, 4'd6, eq);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_alu_op", 32'(ifc.alu_op), 32'h0);
        chk("rst_rv", 32'(ifc.result_valid), 32'd0);
        chk("rst_busy", 32'(ifc.ctrl_busy), 32'd0);
        chk("rst_result", 32'(ifc.result), 32'd0);
        @(negedge clk);
        chk("rst_alu_busy", 32'(ifc.alu_busy), 32'd0);

        // WAIT timeout boundary: busy for TIMEOUT cycles completes, one more errs
        mul_len = 31;
        expr(4'd7, KEY_MUL, 4'd6, eq);
        wait_evt(1'b0, 60, at);
        chk("to_edge_latency", 32'(at - eq), 32'd33);
        chk("to_edge_result", 32'(ifc.result), 32'h2A);
        mul_len = 32;
        expr(4'd7, KEY_MUL, 4'd6, eq);
        wait_evt(1'b1, 60, at);
        chk("to_err_latency", 32'(at - eq), 32'd33);
        press(KEY_CLR, t);
        mul_len = 9;

        // Random key stream checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            for (int w = 0; w < 100 && m_phase == P_RUN; w++) @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 50)      k = 4'($urandom_range(0, 9));
            else if (r < 75) k = 4'($urandom_range(10, 13));
            else if (r < 91) k = KEY_EQ;
            else             k = KEY_CLR;
            if (k == KEY_EQ) mul_len = lens[$urandom_range(0, 4)];
            press(k, t);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (50) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
